// File: rtl/clock_enable_gen.sv
// clock_enable_gen
// Derives NUM_CH independent clock-enable pulse streams from one master clock.
// Each channel runs a fractional mul/div phase accumulator. Ratios can be
// reprogrammed at run time through a single-entry config shadow. All channels
// can also be phase-realigned together with sync_restart.
// Optional feature: define CLKENA_SQUARE_EN to add the clk_sq debug outputs.
// Each clk_sq bit is a divided-by-2 square wave of its enable stream.
module clock_enable_gen #(
    parameter int NUM_CH      = 5,
    parameter int ACC_W       = 16,
    parameter int LOCK_CYCLES = 16,
    parameter logic [NUM_CH*ACC_W-1:0] DEF_MUL = {NUM_CH{{(ACC_W-1){1'b0}}, 1'b1}},
    parameter logic [NUM_CH*ACC_W-1:0] DEF_DIV = {NUM_CH{{(ACC_W-1){1'b0}}, 1'b1}}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sync_restart,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [2:0]        cfg_ch,
    input  logic [ACC_W-1:0]  cfg_mul,
    input  logic [ACC_W-1:0]  cfg_div,
    output logic              cfg_err,
    output logic              locked,
    output logic [NUM_CH-1:0] ena
`ifdef CLKENA_SQUARE_EN
    ,
    output logic [NUM_CH-1:0] clk_sq
`endif
);

    localparam int LCW = $clog2(LOCK_CYCLES + 1);

    // A config is legal when it targets an existing channel and describes a
    // rate no faster than the master clock.
    function automatic logic cfg_legal(input logic [2:0]       ch,
                                       input logic [ACC_W-1:0] mul,
                                       input logic [ACC_W-1:0] div);
        return (int'(ch) < NUM_CH) && (div != {ACC_W{1'b0}}) && (mul <= div);
    endfunction

    logic [LCW-1:0]                lock_cnt_q, lock_cnt_d;
    logic                          locked_q, locked_d;
    logic [NUM_CH-1:0][ACC_W-1:0]  acc_q, acc_d;
    logic [NUM_CH-1:0][ACC_W-1:0]  mul_q, mul_d;
    logic [NUM_CH-1:0][ACC_W-1:0]  div_q, div_d;
    logic [NUM_CH-1:0][ACC_W:0]    sum_s;
    logic [NUM_CH-1:0]             hit_s;
    logic [NUM_CH-1:0]             apply_s;
    logic [NUM_CH-1:0]             ena_q, ena_d;
    logic                          cfg_ready_q, cfg_ready_d;
    logic                          cfg_err_q, cfg_err_d;
    logic [2:0]                    sh_ch_q, sh_ch_d;
    logic [ACC_W-1:0]              sh_mul_q, sh_mul_d;
    logic [ACC_W-1:0]              sh_div_q, sh_div_d;
    logic                          cfg_take_s;

    assign cfg_take_s = cfg_valid && cfg_ready_q;

    // Lock counter: count master cycles after reset until LOCK_CYCLES, then latch locked.
    always_comb begin
        lock_cnt_d = lock_cnt_q;
        locked_d   = locked_q;
        if (!locked_q) begin
            lock_cnt_d = lock_cnt_q + {{(LCW-1){1'b0}}, 1'b1};
            locked_d   = (lock_cnt_d == LCW'(LOCK_CYCLES));
        end else begin
            lock_cnt_d = lock_cnt_q;
        end
    end

    // Per-channel sum, pulse detection and shadow apply point.
    // A busy channel takes the new ratio on an old-ratio pulse. A disabled
    // channel takes it at once.
    always_comb begin
        sum_s   = '0;
        hit_s   = '0;
        apply_s = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sum_s[i]   = {1'b0, acc_q[i]} + {1'b0, mul_q[i]};
            hit_s[i]   = locked_q && (mul_q[i] != {ACC_W{1'b0}}) &&
                         (sum_s[i] >= {1'b0, div_q[i]});
            apply_s[i] = locked_q && !cfg_ready_q && (sh_ch_q == 3'(i)) &&
                         ((mul_q[i] == {ACC_W{1'b0}}) || hit_s[i]);
        end
    end

    // Accumulator, ratio and enable next-state for every channel.
    always_comb begin
        acc_d = acc_q;
        mul_d = mul_q;
        div_d = div_q;
        ena_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (apply_s[i]) begin
                // The old-ratio pulse still goes out unless a restart masks it.
                mul_d[i] = sh_mul_q;
                div_d[i] = sh_div_q;
                acc_d[i] = {ACC_W{1'b0}};
                ena_d[i] = hit_s[i] && !sync_restart;
            end else if (!locked_q || sync_restart || (mul_q[i] == {ACC_W{1'b0}})) begin
                acc_d[i] = {ACC_W{1'b0}};
                ena_d[i] = 1'b0;
            end else if (hit_s[i]) begin
                acc_d[i] = ACC_W'(sum_s[i] - {1'b0, div_q[i]});
                ena_d[i] = 1'b1;
            end else begin
                acc_d[i] = sum_s[i][ACC_W-1:0];
                ena_d[i] = 1'b0;
            end
        end
    end

    // Config handshake: accept into the shadow, reject illegal requests, and free the shadow on apply.
    always_comb begin
        cfg_ready_d = cfg_ready_q;
        cfg_err_d   = 1'b0;
        sh_ch_d     = sh_ch_q;
        sh_mul_d    = sh_mul_q;
        sh_div_d    = sh_div_q;
        if (!cfg_ready_q) begin
            if (|apply_s) begin
                cfg_ready_d = 1'b1;
            end else begin
                cfg_ready_d = 1'b0;
            end
        end else if (cfg_take_s) begin
            if (cfg_legal(cfg_ch, cfg_mul, cfg_div)) begin
                sh_ch_d     = cfg_ch;
                sh_mul_d    = cfg_mul;
                sh_div_d    = cfg_div;
                cfg_ready_d = 1'b0;
            end else begin
                cfg_err_d   = 1'b1;
            end
        end else begin
            cfg_ready_d = 1'b1;
        end
    end

    // State registers. Reset restores the default ratios and drops any pending config.
    always_ff @(posedge clk) begin
        if (reset) begin
            lock_cnt_q  <= '0;
            locked_q    <= 1'b0;
            acc_q       <= '0;
            mul_q       <= DEF_MUL;
            div_q       <= DEF_DIV;
            ena_q       <= '0;
            cfg_ready_q <= 1'b1;
            cfg_err_q   <= 1'b0;
            sh_ch_q     <= 3'd0;
            sh_mul_q    <= {ACC_W{1'b0}};
            sh_div_q    <= {ACC_W{1'b0}};
        end else begin
            lock_cnt_q  <= lock_cnt_d;
            locked_q    <= locked_d;
            acc_q       <= acc_d;
            mul_q       <= mul_d;
            div_q       <= div_d;
            ena_q       <= ena_d;
            cfg_ready_q <= cfg_ready_d;
            cfg_err_q   <= cfg_err_d;
            sh_ch_q     <= sh_ch_d;
            sh_mul_q    <= sh_mul_d;
            sh_div_q    <= sh_div_d;
        end
    end

    assign cfg_ready = cfg_ready_q;
    assign cfg_err   = cfg_err_q;
    assign locked    = locked_q;
    assign ena       = ena_q;

`ifdef CLKENA_SQUARE_EN
    logic [NUM_CH-1:0] sq_q, sq_d;

    // Square-wave next state: toggle on each enable; a restart realigns it to 0.
    always_comb begin
        if (sync_restart) begin
            sq_d = '0;
        end else begin
            sq_d = sq_q ^ ena_q;
        end
    end

    // Square-wave register.
    always_ff @(posedge clk) begin
        if (reset) begin
            sq_q <= '0;
        end else begin
            sq_q <= sq_d;
        end
    end

    assign clk_sq = sq_q;
`else
    // Without the debug feature there is no square-wave state.
`endif

endmodule

// File: tb/tb_clock_enable_gen.sv
// Self-checking bench for clock_enable_gen (default parameters).
// A reference model computes each channel's pulses from the floor(n*mul/div)
// pulse-count law. It is compared against the DUT on every falling edge.
// Directed sections pin the model with hand-computed expectations.
module tb_clock_enable_gen;

    localparam int NCH  = 5;
    localparam int AW   = 16;
    localparam int LOCK = 16;

    logic           clk = 1'b0;
    logic           reset;
    logic           sync_restart;
    logic           cfg_valid;
    logic           cfg_ready;
    logic [2:0]     cfg_ch;
    logic [AW-1:0]  cfg_mul;
    logic [AW-1:0]  cfg_div;
    logic           cfg_err;
    logic           locked;
    logic [NCH-1:0] ena;
`ifdef CLKENA_SQUARE_EN
    logic [NCH-1:0] clk_sq;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    clock_enable_gen dut (
        .clk          (clk),
        .reset        (reset),
        .sync_restart (sync_restart),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_ch       (cfg_ch),
        .cfg_mul      (cfg_mul),
        .cfg_div      (cfg_div),
        .cfg_err      (cfg_err),
        .locked       (locked),
        .ena          (ena)
`ifdef CLKENA_SQUARE_EN
        ,
        .clk_sq       (clk_sq)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    longint         m_mul [NCH];
    longint         m_div [NCH];
    longint         m_n   [NCH];   // counting cycles since this channel's phase zero
    int             m_since;       // master cycles since reset release (saturating at LOCK)
    bit             m_pend;
    int             m_sh_ch;
    longint         m_sh_mul, m_sh_div;
    logic [NCH-1:0] x_ena;
    logic           x_locked, x_ready, x_err;
    bit             model_ok = 1'b0;
    bit             m_lk, m_applied, m_p;
    logic [NCH-1:0] m_e;

    // The n-th counting cycle carries a pulse when floor(n*mul/div) steps up.
    function automatic bit pulse_at(input longint mul, input longint div, input longint n);
        return ((n * mul) / div) != (((n - 1) * mul) / div);
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                for (int c = 0; c < NCH; c++) begin
                    m_mul[c] = 1;
                    m_div[c] = 1;
                    m_n[c]   = 0;
                end
                m_since  = 0;
                m_pend   = 1'b0;
                x_ena    = '0;
                x_locked = 1'b0;
                x_ready  = 1'b1;
                x_err    = 1'b0;
                model_ok = 1'b1;
            end else if (model_ok) begin
                m_lk      = (m_since >= LOCK);
                m_applied = 1'b0;
                m_e       = '0;
                if (m_lk) begin
                    for (int c = 0; c < NCH; c++) begin
                        m_p = (m_mul[c] != 0) && pulse_at(m_mul[c], m_div[c], m_n[c] + 1);
                        if (m_pend && (m_sh_ch == c) && ((m_mul[c] == 0) || m_p)) begin
                            m_mul[c]  = m_sh_mul;
                            m_div[c]  = m_sh_div;
                            m_n[c]    = 0;
                            m_e[c]    = m_p && !sync_restart;
                            m_applied = 1'b1;
                        end else if (sync_restart || (m_mul[c] == 0)) begin
                            m_n[c] = 0;
                        end else begin
                            m_n[c] = m_n[c] + 1;
                            m_e[c] = m_p;
                        end
                    end
                end
                x_err = 1'b0;
                if (m_pend) begin
                    if (m_applied) m_pend = 1'b0;
                end else if (cfg_valid) begin
                    if ((int'(cfg_ch) < NCH) && (cfg_div != 0) && (cfg_mul <= cfg_div)) begin
                        m_pend   = 1'b1;
                        m_sh_ch  = int'(cfg_ch);
                        m_sh_mul = longint'(cfg_mul);
                        m_sh_div = longint'(cfg_div);
                    end else begin
                        x_err = 1'b1;
                    end
                end
                if (m_since < LOCK) m_since++;
                x_locked = (m_since >= LOCK);
                x_ena    = m_e;
                x_ready  = !m_pend;
            end
        end
    end

    // Compare every output against the model on each falling edge.
    always @(negedge clk) begin
        if (model_ok) begin
            check("model_ena",    32'(ena),       32'(x_ena));
            check("model_locked", 32'(locked),    32'(x_locked));
            check("model_ready",  32'(cfg_ready), 32'(x_ready));
            check("model_err",    32'(cfg_err),   32'(x_err));
        end
    end

    // ---------------- stimulus ----------------
    task automatic send_cfg(input logic [2:0] ch, input logic [AW-1:0] m, input logic [AW-1:0] d);
        cfg_valid = 1'b1;
        cfg_ch    = ch;
        cfg_mul   = m;
        cfg_div   = d;
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic wait_ready(input string name, input int limit);
        int k;
        k = 0;
        while ((cfg_ready !== 1'b1) && (k < limit)) begin
            @(negedge clk);
            k++;
        end
        check(name, 32'(cfg_ready), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k, cnt0, cnt1, last0, last1, gmin0, gmax0, gmax1;
        logic [NCH-1:0] expv;

        reset = 1'b1; sync_restart = 1'b0; cfg_valid = 1'b0;
        cfg_ch = 3'd0; cfg_mul = '0; cfg_div = '0;
        repeat (3) @(negedge clk);
        check("rst_locked", 32'(locked),    32'd0);
        check("rst_ena",    32'(ena),       32'd0);
        check("rst_ready",  32'(cfg_ready), 32'd1);
        check("rst_err",    32'(cfg_err),   32'd0);
        reset = 1'b0;

        // Lock: locked rises after exactly LOCK edges; enables stay low until then.
        for (int i = 1; i <= LOCK; i++) begin
            @(negedge clk);
            check("lock_rise",    32'(locked), 32'(i == LOCK));
            check("ena_pre_lock", 32'(ena),    32'd0);
        end
        @(negedge clk);
        check("ena_first_all", 32'(ena), 32'h1F);

        // ch0 1/4 and ch1 3/7.
        send_cfg(3'd0, 16'd1, 16'd4);
        check("ready_drop0", 32'(cfg_ready), 32'd0);
        wait_ready("apply_ch0", 8);
        send_cfg(3'd1, 16'd3, 16'd7);
        check("ready_drop1", 32'(cfg_ready), 32'd0);
        wait_ready("apply_ch1", 8);
        cnt0 = 0; cnt1 = 0; last0 = -1; last1 = -1; gmin0 = 1000; gmax0 = 0; gmax1 = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (ena[0]) begin
                cnt0++;
                if (last0 >= 0) begin
                    if (i - last0 < gmin0) gmin0 = i - last0;
                    if (i - last0 > gmax0) gmax0 = i - last0;
                end
                last0 = i;
            end
            if ((i < 700) && ena[1]) begin
                cnt1++;
                if ((last1 >= 0) && (i - last1 > gmax1)) gmax1 = i - last1;
                last1 = i;
            end
        end
        check("ch0_count_1000", 32'(cnt0),  32'd250);
        check("ch0_gap_min",    32'(gmin0), 32'd4);
        check("ch0_gap_max",    32'(gmax0), 32'd4);
        check("ch1_count_700",  32'(cnt1),  32'd300);
        check("ch1_gap_max",    32'(gmax1), 32'd3);

        // Rejected configs: bad channel, then mul > div.
        send_cfg(3'd6, 16'd1, 16'd1);
        check("err_bad_ch",   32'(cfg_err),   32'd1);
        check("ready_bad_ch", 32'(cfg_ready), 32'd1);
        @(negedge clk);
        check("err_once_ch",  32'(cfg_err),   32'd0);
        send_cfg(3'd0, 16'd5, 16'd4);
        check("err_mul_gt_div",   32'(cfg_err),   32'd1);
        check("ready_mul_gt_div", 32'(cfg_ready), 32'd1);
        @(negedge clk);
        check("err_once_mul",     32'(cfg_err),   32'd0);
        cnt0 = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ena[0]) cnt0++;
        end
        check("ch0_unchanged_40", 32'(cnt0), 32'd10);

        // ch2 at 1/8, then 1/2 offered mid-period while a second request is refused.
        send_cfg(3'd2, 16'd1, 16'd8);
        wait_ready("apply_ch2_8", 8);
        k = 0;
        while ((ena[2] !== 1'b1) && (k < 20)) begin
            @(negedge clk);
            k++;
        end
        check("ch2_pulse_seen", 32'(ena[2]), 32'd1);
        repeat (2) @(negedge clk);
        send_cfg(3'd2, 16'd1, 16'd2);
        check("ch2_pending", 32'(cfg_ready), 32'd0);
        send_cfg(3'd3, 16'd0, 16'd1);
        check("second_not_taken", 32'(cfg_err), 32'd0);
        k = 0;
        while ((cfg_ready !== 1'b1) && (k < 12)) begin
            @(negedge clk);
            k++;
        end
        check("ch2_wait_len",  32'(k),      32'd4);
        check("ch2_old_pulse", 32'(ena[2]), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check("ch2_half_rate", 32'(ena[2]), 32'(i % 2 == 0));
            check("ch3_untouched", 32'(ena[3]), 32'd1);
        end

        // sync_restart with ch0 1/3 and ch1 1/5.
        send_cfg(3'd0, 16'd1, 16'd3);
        wait_ready("apply_ch0_3", 8);
        send_cfg(3'd1, 16'd1, 16'd5);
        wait_ready("apply_ch1_5", 8);
        sync_restart = 1'b1;
        @(negedge clk);
        sync_restart = 1'b0;
        check("restart_ena_zero", 32'(ena), 32'd0);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            expv = {1'b1, 1'b1, (i % 2 == 0), (i == 5), (i == 3)};
            check("restart_align", 32'(ena), 32'(expv));
        end

        // Randomised traffic checked by the model.
        for (int i = 0; i < 3000; i++) begin
            reset        = ($urandom_range(0, 599) == 0);
            sync_restart = ($urandom_range(0, 39) == 0);
            cfg_valid    = ($urandom_range(0, 3) == 0);
            cfg_ch       = 3'($urandom_range(0, 5));
            cfg_mul      = AW'($urandom_range(0, 9));
            cfg_div      = AW'($urandom_range(0, 9));
            @(negedge clk);
        end
        reset = 1'b0; sync_restart = 1'b0; cfg_valid = 1'b0;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/clock_enable_gen.md
Name: clock_enable_gen

Overview:
- Parametrised successor to the fixed five-output PLL block.
- Derives NUM_CH independent clock-enable streams from one fast master clock using fractional (mul/div) phase accumulators.
- Ratios are reprogrammable at run time and channels can be phase-realigned together.
- Sits beside the PLL. Feeds the PPU, 6502, VGA and APU enables so downstream logic runs on one clock domain.

Parameters:
- NUM_CH, 5, number of enable channels (1..8)
- ACC_W, 16, width of mul, div and accumulator per channel
- LOCK_CYCLES, 16, master cycles after reset before enables are released (>=1)
- DEF_MUL, {NUM_CH{16'd1}}, packed per-channel reset multiplier (channel i at [i*ACC_W +: ACC_W])
- DEF_DIV, {NUM_CH{16'd1}}, packed per-channel reset divisor

Ports:
- clk  in  1  master clock
- reset  in  1  synchronous, active-high reset
- sync_restart  in  1  one-cycle request to zero all accumulators (phase align)
- cfg_valid  in  1  new ratio offered
- cfg_ready  out  1  config shadow free
- cfg_ch  in  3  target channel index
- cfg_mul  in  ACC_W  enable pulses per cfg_div master cycles
- cfg_div  in  ACC_W  ratio denominator
- cfg_err  out  1  one-cycle pulse, config rejected
- locked  out  1  enables released
- ena  out  NUM_CH  one-cycle enable pulse per channel

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, on reset.
- Reset values:
  - ena=0, locked=0, cfg_ready=1, cfg_err=0.
  - Accumulators=0; mul/div loaded from DEF_MUL/DEF_DIV; shadow cleared.
  - A reset mid-pending drops the pending config.
- Lock counter:
  - Counts master cycles after reset deassertion.
  - locked rises on the cycle the count reaches LOCK_CYCLES and stays high until the next reset.
  - While locked=0, all ena=0 and accumulators hold at 0.
- Per-channel accumulator (locked=1, mul!=0):
  - s = acc + mul, computed ACC_W+1 bits wide with no overflow.
  - If s >= div: acc <= s - div and ena[i] <= 1. Otherwise acc <= s and ena[i] <= 0.
  - ena is registered. The first pulse of a mul=div channel appears 1 cycle after locked rises.
  - Long-run pulse rate is exactly mul/div of clk. Jitter is at most 1 cycle; there is no drift.
- mul=0: channel disabled, ena[i]=0, acc holds 0.
- mul=div: ena[i] high every cycle.
- Config handshake:
  - Transfer occurs when cfg_valid && cfg_ready.
  - Rejected (cfg_err pulse the next cycle, no state change, cfg_ready stays 1) when any of these hold: cfg_ch >= NUM_CH, cfg_div=0, or cfg_mul > cfg_div.
  - An accepted config goes into a single shadow register, and cfg_ready drops to 0 the next cycle.
- Apply point:
  - If the target channel is disabled (mul=0), the shadow applies the cycle after acceptance.
  - Otherwise it applies on the cycle that channel emits a pulse at the old ratio.
  - On apply: mul/div are updated, acc <= 0, and cfg_ready returns to 1 the following cycle.
  - A pending config is never applied while locked=0.
- sync_restart:
  - All accumulators are zeroed on the next edge, and ena is 0 that cycle.
  - Counting resumes from zero on all channels simultaneously.
  - locked is unaffected.
  - If a channel's pending apply point coincides with sync_restart, the apply wins (acc=0 anyway).
- Simultaneous reset and anything else: reset wins.

Optional Feature:
- CLKENA_SQUARE_EN defined:
  - Adds output port clk_sq [NUM_CH].
  - Each bit toggles on every cycle its ena bit is 1, giving a divided-by-2 square wave for scope and debug pins.
  - Reset value 0; cleared by sync_restart.
- CLKENA_SQUARE_EN undefined: port and registers are absent. All other behaviour is identical.

Test Plan:
- Reset with LOCK_CYCLES=16, DEF ratios 1/1 -> locked rises 16 cycles after reset release; ena=5'b11111 from the next cycle; ena=0 before that.
- Config ch0 mul=1 div=4 -> exactly one ena[0] pulse every 4 cycles; 250 pulses in 1000 cycles.
- Config ch1 mul=3 div=7 -> 300 pulses in 700 cycles; no gap exceeds 3 cycles.
- Config with cfg_ch=6 (NUM_CH=5), and separately mul=5 div=4 -> cfg_err pulses once each, cfg_ready stays 1, ratios unchanged.
- Ch2 at 1/8, new config 1/2 accepted mid-period -> cfg_ready low until ch2's next old-ratio pulse; thereafter pulses every 2 cycles; second cfg_valid during pending is not accepted.
- Ch0 1/3 and ch1 1/5 running, assert sync_restart -> ena=0 the next cycle; ch0 and ch1 first pulses land 3 and 5 cycles later, both aligned to the restart edge.
